// File: rtl/fb_pkg.sv
// Shared constants, state encoding and pipeline record types for the framebuffer write path.
// Pure definitions: no latency and no flow control of its own.
package fb_pkg;

   localparam int FB_H_RES  = 320;
   localparam int FB_V_RES  = 240;
   localparam int FB_PIXELS = FB_H_RES * FB_V_RES;
   localparam int FB_ADDR_W = 17;

   typedef enum logic {CLEAR, DRAW} fb_state_e;

   // One pixel travelling from handshake to the depth-test stage.
   typedef struct packed {
      logic                 vld;
      logic [FB_ADDR_W-1:0] addr;
      logic [15:0]          z;
      logic [11:0]          rgb;
   } pix_t;

   typedef struct packed {
      logic                 vld;
      logic [FB_ADDR_W-1:0] addr;
      logic [15:0]          z;
   } zwr_t;

   // Linear address for a 320-pixel line: y*256 + y*64 + x.
   function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
      logic [FB_ADDR_W-1:0] yw;
      yw = {{(FB_ADDR_W-8){1'b0}}, y};
      return (yw << 8) + (yw << 6) + {{(FB_ADDR_W-9){1'b0}}, x};
   endfunction

endpackage

// File: rtl/depth_bypass.sv
// History of the last DEPTH depth writes, newest in slot 0; forwards the newest z matching rd_addr.
// Lookup is combinational (same cycle); flush empties the history on the next edge, never stalls.
module depth_bypass
   import fb_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 wr_vld,
   input  logic [FB_ADDR_W-1:0] wr_addr,
   input  logic [15:0]          wr_z,
   input  logic [FB_ADDR_W-1:0] rd_addr,
   output logic                 hit,
   output logic [15:0]          fwd_z
);

   zwr_t hist [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      end else begin
         hist[0] <= '{vld: wr_vld, addr: wr_addr, z: wr_z};
         for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
      end
   end

   // Scan oldest to newest so the newest matching write overrides older ones.
   always_comb begin
      hit   = 1'b0;
      fwd_z = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (hist[i].vld && (hist[i].addr == rd_addr)) begin
            hit   = 1'b1;
            fwd_z = hist[i].z;
         end
      end
   end

endmodule

// File: rtl/framebuffer_ctrl.sv
// Framebuffer write controller: buffer select, back-buffer clear walk, depth-tested read-modify-write.
// Pixel writes strobe RD_LATENCY+2 cycles after handshake; ready_out is low while clearing, no stalls in DRAW.
module framebuffer_ctrl
   import fb_pkg::*;
#(
   parameter int          H_RES      = FB_H_RES,
   parameter int          V_RES      = FB_V_RES,
   parameter int          RD_LATENCY = 2,
   parameter logic [15:0] CLEAR_Z    = 16'hFFFF,
   parameter logic [11:0] CLEAR_RGB  = 12'h000
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 clear_in,
   input  logic                 switch_in,
   input  logic                 valid_in,
   output logic                 ready_out,
   input  logic [8:0]           x_in,
   input  logic [7:0]           y_in,
   input  logic [15:0]          z_in,
   input  logic [11:0]          rgb_in,
   output logic                 front_sel_out,
   output logic [FB_ADDR_W-1:0] depth_rd_addr_out,
   input  logic [15:0]          depth_rd_data_in,
   output logic [FB_ADDR_W-1:0] wr_addr_out,
   output logic                 depth_wr_en_out,
   output logic [15:0]          depth_wr_data_out,
   output logic                 color_wr_en_out,
   output logic [11:0]          color_wr_data_out,
   output logic [FB_ADDR_W-1:0] drawn_count_out
);

   localparam int                   NSTG      = RD_LATENCY + 1;
   localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(H_RES * V_RES - 1);
   localparam logic [FB_ADDR_W-1:0] MAX_COUNT = FB_ADDR_W'(H_RES * V_RES);
   localparam logic [8:0]           X_LIM     = 9'(H_RES);
   localparam logic [7:0]           Y_LIM     = 8'(V_RES);

   fb_state_e            state, next_state;
   logic [FB_ADDR_W-1:0] clr_addr;
   logic                 clr_last;
   logic                 accept;
   logic                 in_range;
   pix_t                 stage_in;
   pix_t                 pipe [NSTG];
   logic                 hit;
   logic [15:0]          fwd_z;
   logic [15:0]          stored_z;
   logic                 pass;

   assign clr_last = (clr_addr == LAST_ADDR);
   assign accept   = valid_in && ready_out;
   assign in_range = (x_in < X_LIM) && (y_in < Y_LIM);
   assign stage_in = '{vld: accept && in_range, addr: pix_addr(x_in, y_in), z: z_in, rgb: rgb_in};

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state <= CLEAR;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (clear_in)                       next_state = CLEAR;
      else if (state == CLEAR && clr_last) next_state = DRAW;
   end

   // ready_out trails the DRAW transition by one cycle but drops immediately on clear_in.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         clr_addr      <= '0;
         ready_out     <= 1'b0;
         front_sel_out <= 1'b0;
      end else begin
         if (clear_in || state != CLEAR || clr_last) clr_addr <= '0;
         else                                        clr_addr <= clr_addr + FB_ADDR_W'(1);
         ready_out <= !clear_in && (state == DRAW);
         if (switch_in) front_sel_out <= !front_sel_out;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < NSTG; i++) pipe[i] <= '0;
      end else if (clear_in) begin
         for (int i = 0; i < NSTG; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= stage_in;
         for (int i = 1; i < NSTG; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign depth_rd_addr_out = pipe[0].addr;

   // Writes issued since this pixel's read are not yet in the read data; take them from the history.
   depth_bypass #(
      .DEPTH (RD_LATENCY + 1)
   ) u_bypass (
      .clk     (clk_in),
      .rst     (rst_in),
      .flush   (clear_in),
      .wr_vld  (pass),
      .wr_addr (pipe[NSTG-1].addr),
      .wr_z    (pipe[NSTG-1].z),
      .rd_addr (pipe[NSTG-1].addr),
      .hit     (hit),
      .fwd_z   (fwd_z)
   );

   assign stored_z = hit ? fwd_z : depth_rd_data_in;
   assign pass     = pipe[NSTG-1].vld && (pipe[NSTG-1].z < stored_z);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_addr_out       <= '0;
         depth_wr_en_out   <= 1'b0;
         depth_wr_data_out <= '0;
         color_wr_en_out   <= 1'b0;
         color_wr_data_out <= '0;
         drawn_count_out   <= '0;
      end else if (clear_in) begin
         depth_wr_en_out <= 1'b0;
         color_wr_en_out <= 1'b0;
         drawn_count_out <= '0;
      end else if (state == CLEAR) begin
         wr_addr_out       <= clr_addr;
         depth_wr_en_out   <= 1'b1;
         depth_wr_data_out <= CLEAR_Z;
         color_wr_en_out   <= 1'b1;
         color_wr_data_out <= CLEAR_RGB;
      end else begin
         wr_addr_out       <= pipe[NSTG-1].addr;
         depth_wr_en_out   <= pass;
         depth_wr_data_out <= pipe[NSTG-1].z;
         color_wr_en_out   <= pass;
         color_wr_data_out <= pipe[NSTG-1].rgb;
         if (pass && drawn_count_out != MAX_COUNT)
            drawn_count_out <= drawn_count_out + FB_ADDR_W'(1);
      end
   end

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Directed bench for framebuffer_ctrl with a read-first depth BRAM model; short frame (16 lines) keeps clears brief.
module tb_framebuffer_ctrl;

   localparam int RDL = 2;
   localparam int VR  = 16;
   localparam int PIX = 320 * VR;
   localparam int MID = 2000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear_in = 1'b0, switch_in = 1'b0, valid_in = 1'b0;
   logic [8:0]  x_in = '0;
   logic [7:0]  y_in = '0;
   logic [15:0] z_in = '0;
   logic [11:0] rgb_in = '0;
   logic        ready_out, front_sel_out, depth_wr_en_out, color_wr_en_out;
   logic [16:0] depth_rd_addr_out, wr_addr_out, drawn_count_out;
   logic [15:0] depth_rd_data, depth_wr_data_out;
   logic [11:0] color_wr_data_out;

   int cyc = 0;
   int nchk = 0;
   int nerr = 0;

   typedef struct {
      logic [16:0] addr;
      logic [15:0] z;
      logic [11:0] rgb;
      logic        den;
      logic        cen;
      int          cyc;
   } wr_t;
   wr_t wq[$];
   wr_t w;

   typedef struct {
      int x;
      int y;
      int z;
      int rgb;
      int nwr;
      int addr;
   } vec_t;
   vec_t vt[10];

   logic [15:0] mem [0:131071];
   logic [15:0] rdp [0:3];

   framebuffer_ctrl #(
      .V_RES      (VR),
      .RD_LATENCY (RDL)
   ) dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .clear_in          (clear_in),
      .switch_in         (switch_in),
      .valid_in          (valid_in),
      .ready_out         (ready_out),
      .x_in              (x_in),
      .y_in              (y_in),
      .z_in              (z_in),
      .rgb_in            (rgb_in),
      .front_sel_out     (front_sel_out),
      .depth_rd_addr_out (depth_rd_addr_out),
      .depth_rd_data_in  (depth_rd_data),
      .wr_addr_out       (wr_addr_out),
      .depth_wr_en_out   (depth_wr_en_out),
      .depth_wr_data_out (depth_wr_data_out),
      .color_wr_en_out   (color_wr_en_out),
      .color_wr_data_out (color_wr_data_out),
      .drawn_count_out   (drawn_count_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Read-first BRAM: the read samples the old word when a write hits the same address.
   always @(posedge clk) begin
      rdp[0] <= mem[depth_rd_addr_out];
      for (int i = 1; i < 4; i++) rdp[i] <= rdp[i-1];
      if (depth_wr_en_out) mem[wr_addr_out] <= depth_wr_data_out;
   end
   assign depth_rd_data = rdp[RDL-1];

   always @(negedge clk) begin
      if (!rst && (depth_wr_en_out || color_wr_en_out)) begin
         w.addr = wr_addr_out;
         w.z    = depth_wr_data_out;
         w.rgb  = color_wr_data_out;
         w.den  = depth_wr_en_out;
         w.cen  = color_wr_en_out;
         w.cyc  = cyc;
         wq.push_back(w);
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic pix(input int x, input int y, input int z, input int rgb);
      valid_in = 1'b1;
      x_in     = 9'(x);
      y_in     = 8'(y);
      z_in     = 16'(z);
      rgb_in   = 12'(rgb);
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Called #1 after the edge that started a clear, with the write log emptied.
   task automatic wait_clear(input string nm);
      int n;
      int bad;
      n   = 0;
      bad = 0;
      while (ready_out !== 1'b1 && n < PIX + 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_ready_cycles"}, n, PIX + 1);
      chk({nm, "_nwrites"}, wq.size(), PIX);
      foreach (wq[i]) begin
         if (wq[i].addr != 17'(i) || wq[i].z != 16'hFFFF || wq[i].rgb != 12'h000 ||
             wq[i].den != 1'b1 || wq[i].cen != 1'b1)
            bad++;
      end
      chk({nm, "_bad_writes"}, bad, 0);
      chk({nm, "_drawn"}, drawn_count_out, 0);
   endtask

   initial begin
      int c;
      int n;

      vt[0] = '{10,  5,   100,     'hF00, 1, 1610};
      vt[1] = '{10,  5,   100,     'h0F0, 0, 0};
      vt[2] = '{10,  5,   99,      'h00F, 1, 1610};
      vt[3] = '{320, 5,   1,       'hFFF, 0, 0};
      vt[4] = '{0,   16,  1,       'hFFF, 0, 0};
      vt[5] = '{0,   240, 1,       'hFFF, 0, 0};
      vt[6] = '{319, 15,  'hFFFF,  'h111, 0, 0};
      vt[7] = '{319, 15,  'hFFFE,  'hABC, 1, 5119};
      vt[8] = '{0,   0,   0,       'h123, 1, 0};
      vt[9] = '{0,   0,   0,       'h456, 0, 0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", ready_out, 0);
      chk("rst_depth_en", depth_wr_en_out, 0);
      chk("rst_color_en", color_wr_en_out, 0);
      chk("rst_front", front_sel_out, 0);
      chk("rst_drawn", drawn_count_out, 0);
      rst = 1'b0;
      wq.delete();
      wait_clear("rst_clear");
      chk("rst_clear_front", front_sel_out, 0);

      for (int i = 0; i < 10; i++) begin
         wq.delete();
         c = cyc;
         pix(vt[i].x, vt[i].y, vt[i].z, vt[i].rgb);
         idle(RDL + 4);
         chk($sformatf("v%0d_nwr", i), wq.size(), vt[i].nwr);
         if (vt[i].nwr == 1 && wq.size() == 1) begin
            chk($sformatf("v%0d_addr", i), wq[0].addr, vt[i].addr);
            chk($sformatf("v%0d_z", i), wq[0].z, vt[i].z);
            chk($sformatf("v%0d_rgb", i), wq[0].rgb, vt[i].rgb);
            chk($sformatf("v%0d_both_en", i), {wq[0].den, wq[0].cen}, 2'b11);
            chk($sformatf("v%0d_latency", i), wq[0].cyc - c, RDL + 2);
         end
         chk($sformatf("v%0d_ready", i), ready_out, 1);
      end
      chk("vec_drawn", drawn_count_out, 4);

      // Back-to-back pixels at one address: 200 loses to the in-flight 100, 50 beats it.
      wq.delete();
      pix(20, 3, 100, 1);
      pix(20, 3, 200, 2);
      pix(20, 3, 50, 3);
      idle(RDL + 4);
      chk("b2b_nwr", wq.size(), 2);
      if (wq.size() == 2) begin
         chk("b2b_addr", wq[0].addr, 980);
         chk("b2b_z0", wq[0].z, 100);
         chk("b2b_rgb0", wq[0].rgb, 1);
         chk("b2b_z1", wq[1].z, 50);
         chk("b2b_rgb1", wq[1].rgb, 3);
         chk("b2b_gap", wq[1].cyc - wq[0].cyc, 2);
      end
      chk("b2b_mem", mem[980], 50);
      chk("b2b_drawn", drawn_count_out, 6);

      // Spacing RDL+1: the second read lands in the same cycle as the first write (oldest history slot).
      wq.delete();
      pix(40, 7, 500, 5);
      idle(RDL);
      pix(40, 7, 600, 6);
      idle(RDL + 1);
      pix(40, 7, 550, 7);
      idle(RDL + 1);
      pix(40, 7, 450, 8);
      idle(RDL + 4);
      chk("gap_nwr", wq.size(), 2);
      if (wq.size() == 2) begin
         chk("gap_addr", wq[1].addr, 2280);
         chk("gap_z0", wq[0].z, 500);
         chk("gap_z1", wq[1].z, 450);
         chk("gap_rgb1", wq[1].rgb, 8);
      end
      chk("gap_mem", mem[2280], 450);
      chk("gap_drawn", drawn_count_out, 8);

      switch_in = 1'b1;
      @(posedge clk); #1;
      switch_in = 1'b0;
      chk("sw_front", front_sel_out, 1);
      chk("sw_ready", ready_out, 1);

      // Clear + switch together with two pixels in flight; valid held high during the clear.
      wq.delete();
      pix(50, 2, 1, 'hAAA);
      valid_in  = 1'b1;
      x_in      = 9'd51;
      y_in      = 8'd2;
      z_in      = 16'd1;
      rgb_in    = 12'hBBB;
      clear_in  = 1'b1;
      switch_in = 1'b1;
      @(posedge clk); #1;
      clear_in  = 1'b0;
      switch_in = 1'b0;
      wq.delete();
      chk("clrsw_ready_low", ready_out, 0);
      chk("clrsw_front", front_sel_out, 0);
      x_in   = 9'd60;
      y_in   = 8'd4;
      z_in   = 16'd0;
      rgb_in = 12'hCCC;
      wait_clear("clrsw");
      valid_in = 1'b0;

      // Restart a clear part-way through.
      clear_in = 1'b1;
      @(posedge clk); #1;
      clear_in = 1'b0;
      wq.delete();
      n = 0;
      while (wq.size() < MID && n < MID + 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("mid_reached", wq.size(), MID);
      clear_in = 1'b1;
      @(posedge clk); #1;
      clear_in = 1'b0;
      wq.delete();
      chk("mid_ready_low", ready_out, 0);
      wait_clear("midclr");
      chk("mid_front", front_sel_out, 0);

      wq.delete();
      pix(10, 5, 100, 'hF00);
      idle(RDL + 4);
      chk("post_nwr", wq.size(), 1);
      if (wq.size() == 1) chk("post_z", wq[0].z, 100);
      chk("post_drawn", drawn_count_out, 1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
